alu_mc: RTL
===========

Name: alu_mc

Overview:
- Parametrised multi-cycle successor of the single-cycle datapath ALU.
- Executes the full MIPS integer op set: shifts, logic, add/sub, slt/sltu and lui in 1 cycle, plus iterative mult/multu/div/divu into HI/LO.
- Sits in the EX stage. The control unit holds the pipeline while busy=1 and proceeds on the done pulse.

Parameters:
- WIDTH, 32: datapath width in bits; must be even and at least 8.
- SHW, $clog2(WIDTH): shift-amount width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  launch operation; sampled only when busy=0
- op  in  5  operation select; encoding below
- a  in  WIDTH  operand 1; for variable shifts, the shift amount
- b  in  WIDTH  operand 2; for immediate shifts, the shift amount
- result  out  WIDTH  registered single-cycle result
- zero  out  1  registered (result == 0)
- hi  out  WIDTH  HI register (product high half / remainder)
- lo  out  WIDTH  LO register (product low half / quotient)
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse when result/hi/lo are valid
- div_zero  out  1  sticky until next start: last div/divu had b=0

Behaviour:
- Reset (synchronous): result=0, zero=1, hi=0, lo=0, busy=0, done=0, div_zero=0, FSM=IDLE. Reset mid-operation aborts immediately; no done pulse follows.
- op[4]=0, single-cycle ops; shift amount sh = low SHW bits of the named operand:
  - 0001 sll: a<<b[sh]
  - 0010 srl: a>>b[sh]
  - 0011 sra: signed a>>>b[sh]
  - 0100 sllv: b<<a[sh]
  - 0101 srlv: b>>a[sh]
  - 0110 srav: signed b>>>a[sh]
  - 0111 lui: b<<(WIDTH/2)
  - 1000 add, 1001 sub (wrap modulo 2^WIDTH)
  - 1010 and, 1011 or, 1100 xor, 1101 nor
  - 1110 slt (signed), 1111 sltu (unsigned): 1 or 0, zero-extended
  - 0000: add
- op[4]=1, multi-cycle ops on op[1:0]: 00 mult, 01 multu, 10 div, 11 divu. Writes hi/lo only; result and zero hold their previous values.
- FSM: IDLE, RUN, FIX.
  - IDLE with start and op[4]=0: result/zero registered at that edge. done=1 in the following cycle. busy stays 0. Latency 1.
  - IDLE with start and op[4]=1: latch the magnitudes of a and b (signed ops take the absolute value; the most negative value is treated as unsigned 2^(WIDTH-1)). Latch the sign flags. busy=1, counter=0, go to RUN.
  - RUN: one iteration per cycle for exactly WIDTH cycles. mult uses shift-add; div uses restoring shift-subtract. Then go to FIX.
  - FIX: apply sign correction. Signed mult negates the 2W product if sign(a)^sign(b). Signed div: quotient sign = sign(a)^sign(b); remainder sign = sign(a). Write hi/lo, busy=0, done=1 for one cycle, go to IDLE.
  - Multi-cycle latency: start edge to done cycle = WIDTH+2 cycles.
- Divide by zero (b=0): skip RUN and go straight to FIX. hi=a, lo=all ones, div_zero=1. Latency 2.
- Signed overflow div (most-negative / -1): lo=most negative, hi=0. No flag.
- start while busy=1 is ignored; operand and op changes during RUN have no effect.
- done and start in the same cycle: the new start is accepted (back-to-back allowed).
- hi/lo hold between multi-cycle ops; single-cycle ops never modify them.

Optional Feature:
- Macro: ALU_MC_OVERFLOW_EN.
- Defined: adds output port ovf (1 bit), registered alongside result. ovf=1 when add/sub signed-overflows (operand signs equal and result sign differs; for sub, compare with ~b). ovf=0 for every other op. ovf resets to 0.
- Undefined: the port and its logic are absent; add/sub wrap silently.

Test Plan:
- Reset, then start op=01000 with a=5, b=7 -> next cycle result=12, zero=0, done=1, busy=0. Then op=01001 with a=b=9 -> result=0, zero=1.
- op=00011, a=0x80000000, b=0x24 (sh=4) -> result=0xF8000000. op=00111, b=0x1234 -> result=0x12340000.
- op=10000 (mult), a=-3, b=7 -> busy high for 33 cycles, done at cycle 34: hi=0xFFFFFFFF, lo=0xFFFFFFEB. A start pulse mid-RUN is ignored.
- op=10010 (div), a=-17, b=5 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFE (-2). Then b=0 -> done after 2 cycles, hi=a, lo=0xFFFFFFFF, div_zero=1. The next start clears div_zero.
- Assert reset at RUN cycle 10 of a multu -> all outputs return to reset values the next cycle; no done pulse.
- With ALU_MC_OVERFLOW_EN: add a=0x7FFFFFFF, b=1 -> result=0x80000000, ovf=1. sub a=0, b=1 -> ovf=0.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle MIPS integer ALU.
// Single-cycle ops (shifts, logic, add/sub, slt/sltu, lui) register into result/zero.
// mult/multu/div/divu iterate for WIDTH cycles (shift-add / restoring divide) into hi/lo.
// Optional feature: define ALU_MC_OVERFLOW_EN to add the ovf output for add/sub.
module alu_mc #(
   parameter int unsigned WIDTH = 32,
   localparam int unsigned SHW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
`ifdef ALU_MC_OVERFLOW_EN
   ,
   output logic             ovf
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   logic [1:0]       state_q;
   logic [SHW-1:0]   cnt_q;
   logic [WIDTH-1:0] acc_q;     // product high half / partial remainder
   logic [WIDTH-1:0] q_q;       // multiplier -> product low half / dividend -> quotient
   logic [WIDTH-1:0] m_q;       // multiplicand or divisor magnitude
   logic [1:0]       op_q;
   logic             sa_q, sb_q, dz_q;
   logic [WIDTH-1:0] result_q, hi_q, lo_q;
   logic             zero_q, done_q, div_zero_q;

   // Single-cycle function of the live operands
   logic [SHW-1:0]   sh_a, sh_b;
   logic [WIDTH-1:0] sum, diff, alu_y;
   logic             alu_ovf;
   always_comb begin
      sh_a    = a[SHW-1:0];
      sh_b    = b[SHW-1:0];
      sum     = a + b;
      diff    = a - b;
      alu_y   = sum;
      alu_ovf = 1'b0;
      case (op[3:0])
         4'h1: alu_y = a << sh_b;
         4'h2: alu_y = a >> sh_b;
         4'h3: alu_y = $signed(a) >>> sh_b;
         4'h4: alu_y = b << sh_a;
         4'h5: alu_y = b >> sh_a;
         4'h6: alu_y = $signed(b) >>> sh_a;
         4'h7: alu_y = b << (WIDTH / 2);
         4'h8: begin
            alu_y   = sum;
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         4'h9: begin
            alu_y   = diff;
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         4'hA: alu_y = a & b;
         4'hB: alu_y = a | b;
         4'hC: alu_y = a ^ b;
         4'hD: alu_y = ~(a | b);
         4'hE: alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         4'hF: alu_y = {{(WIDTH-1){1'b0}}, (a < b)};
         default: begin
            alu_y   = sum;
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
      endcase
   end

   // Operand magnitudes at launch; the most negative value maps to 2^(WIDTH-1) unsigned
   logic             sgn_in;
   logic [WIDTH-1:0] abs_a, abs_b;
   always_comb begin
      sgn_in = ~op[0];
      abs_a  = (sgn_in && a[WIDTH-1]) ? -a : a;
      abs_b  = (sgn_in && b[WIDTH-1]) ? -b : b;
   end

   // One iteration of shift-add multiply or restoring divide
   logic [WIDTH:0]   mul_sum, trial;
   logic [WIDTH-1:0] acc_nx, q_nx;
   always_comb begin
      mul_sum = {1'b0, acc_q} + {1'b0, (q_q[0] ? m_q : {WIDTH{1'b0}})};
      trial   = {acc_q, q_q[WIDTH-1]} - {1'b0, m_q};
      if (!op_q[1]) begin
         acc_nx = mul_sum[WIDTH:1];
         q_nx   = {mul_sum[0], q_q[WIDTH-1:1]};
      end else if (!trial[WIDTH]) begin
         acc_nx = trial[WIDTH-1:0];
         q_nx   = {q_q[WIDTH-2:0], 1'b1};
      end else begin
         acc_nx = {acc_q[WIDTH-2:0], q_q[WIDTH-1]};
         q_nx   = {q_q[WIDTH-2:0], 1'b0};
      end
   end

   // Sign correction of the unsigned iteration result
   logic             sgn_q;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0] hi_fix, lo_fix;
   always_comb begin
      sgn_q = ~op_q[0];
      prod  = {acc_q, q_q};
      if (sgn_q && (sa_q ^ sb_q)) prod = -prod;
      hi_fix = prod[2*WIDTH-1:WIDTH];
      lo_fix = prod[WIDTH-1:0];
      if (op_q[1]) begin
         if (dz_q) begin
            // q_q still holds |a|; restoring its sign gives back a
            hi_fix = (sgn_q && sa_q) ? -q_q : q_q;
            lo_fix = {WIDTH{1'b1}};
         end else begin
            hi_fix = (sgn_q && sa_q) ? -acc_q : acc_q;
            lo_fix = (sgn_q && (sa_q ^ sb_q)) ? -q_q : q_q;
         end
      end
   end

`ifdef ALU_MC_OVERFLOW_EN
   logic ovf_q;
`endif

   // Control FSM, single-cycle result registers and iterative datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         q_q        <= '0;
         m_q        <= '0;
         op_q       <= '0;
         sa_q       <= 1'b0;
         sb_q       <= 1'b0;
         dz_q       <= 1'b0;
         result_q   <= '0;
         zero_q     <= 1'b1;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
`ifdef ALU_MC_OVERFLOW_EN
         ovf_q      <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  div_zero_q <= 1'b0;
                  if (!op[4]) begin
                     result_q <= alu_y;
                     zero_q   <= (alu_y == '0);
                     done_q   <= 1'b1;
`ifdef ALU_MC_OVERFLOW_EN
                     ovf_q    <= alu_ovf;
`endif
                  end else begin
                     op_q  <= op[1:0];
                     sa_q  <= sgn_in & a[WIDTH-1];
                     sb_q  <= sgn_in & b[WIDTH-1];
                     acc_q <= '0;
                     cnt_q <= '0;
                     q_q   <= op[1] ? abs_a : abs_b;
                     m_q   <= op[1] ? abs_b : abs_a;
                     dz_q  <= op[1] && (b == '0);
                     state_q <= (op[1] && (b == '0)) ? FIX : RUN;
                  end
               end
            end
            RUN: begin
               acc_q <= acc_nx;
               q_q   <= q_nx;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == SHW'(WIDTH - 1)) state_q <= FIX;
            end
            FIX: begin
               hi_q       <= hi_fix;
               lo_q       <= lo_fix;
               div_zero_q <= dz_q;
               done_q     <= 1'b1;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign result   = result_q;
   assign zero     = zero_q;
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign div_zero = div_zero_q;
`ifdef ALU_MC_OVERFLOW_EN
   assign ovf      = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = alu_ovf;
`endif

endmodule
